// File: rtl/mmult_loader.sv
// mmult_loader: byte-stream loader for the 3x3 matrix multiplier.
// Packs A then B row-major, clears and runs the multiplier, flags timeout.
module mmult_loader #(
  parameter int DATA_W      = 8,
  parameter int N_ELEM      = 9,
  parameter int RUN_TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [0:N_ELEM*DATA_W-1]   A_mat,
  output logic [0:N_ELEM*DATA_W-1]   B_mat,
  output logic                       mm_reset_n,
  output logic                       mm_enable,
  input  logic                       mm_valid,
  output logic                       busy,
  output logic                       done,
  output logic                       error
);

  localparam int MAT_W = N_ELEM * DATA_W;
  localparam int CNT_W = $clog2(2 * N_ELEM);
  localparam int TMR_W = $clog2(RUN_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(2 * N_ELEM - 1);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(RUN_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CLR,
    S_RUN,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [TMR_W-1:0]   r_timer;
  logic [0:MAT_W-1]   r_a;
  logic [0:MAT_W-1]   r_b;
  logic               r_in_ready;
  logic               r_mm_reset_n;
  logic               r_mm_enable;
  logic               r_busy;
  logic               r_done;
  logic               r_error;
  logic               w_accept;
  logic               w_start;
  logic               w_timeout;

  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    w_accept  = r_in_ready && in_valid;
    w_start   = (r_state == S_IDLE) && start;
    unique case (r_state)
      S_IDLE: if (start) w_next = S_LOAD;
      S_LOAD: if (w_accept && r_cnt == LAST_BYTE) w_next = S_CLR;
      S_CLR:  w_next = S_RUN;
      S_RUN: begin
        // mm_valid beats a coincident timeout
        if (mm_valid) begin
          w_next = S_DONE;
        end else if (r_timer == TMR_LAST) begin
          w_next    = S_IDLE;
          w_timeout = 1'b1;
        end
      end
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Outputs are registered from the next state so they align with it
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt        <= '0;
      r_timer      <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_in_ready   <= 1'b0;
      r_mm_reset_n <= 1'b0;
      r_mm_enable  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_in_ready   <= (w_next == S_LOAD);
      r_mm_reset_n <= (w_next != S_CLR);
      r_mm_enable  <= (w_next == S_RUN);
      r_busy       <= (w_next != S_IDLE);
      r_done       <= (w_next == S_DONE);
      if (w_start) begin
        r_cnt   <= '0;
        r_error <= 1'b0;
      end
      if (w_accept) begin
        r_cnt <= r_cnt + CNT_W'(1);
        for (int e = 0; e < N_ELEM; e++) begin
          if (r_cnt == CNT_W'(e))
            r_a[e*DATA_W +: DATA_W] <= in_data;
          if (r_cnt == CNT_W'(e + N_ELEM))
            r_b[e*DATA_W +: DATA_W] <= in_data;
        end
      end
      if (r_state == S_CLR) begin
        r_timer <= '0;
      end else if (r_state == S_RUN) begin
        r_timer <= r_timer + TMR_W'(1);
      end
      if (w_timeout) r_error <= 1'b1;
    end
  end

  assign in_ready   = r_in_ready;
  assign A_mat      = r_a;
  assign B_mat      = r_b;
  assign mm_reset_n = r_mm_reset_n;
  assign mm_enable  = r_mm_enable;
  assign busy       = r_busy;
  assign done       = r_done;
  assign error      = r_error;

endmodule

// File: tb/tb_mmult_loader.sv
// tb_mmult_loader: directed checks of the loader FSM, packing,
// handshake stalls, timeout, and ignored inputs.
module tb_mmult_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [0:71] A_mat;
  logic [0:71] B_mat;
  logic        mm_reset_n;
  logic        mm_enable;
  logic        mm_valid;
  logic        busy;
  logic        done;
  logic        error;

  logic        use_model;
  logic        man_valid;
  logic        mdl_valid;
  int          mcnt;
  logic [7:0]  vec [18];

  int checks;
  int errors;

  mmult_loader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .A_mat      (A_mat),
    .B_mat      (B_mat),
    .mm_reset_n (mm_reset_n),
    .mm_enable  (mm_enable),
    .mm_valid   (mm_valid),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 3-cycle multiplier: valid on the third enabled cycle after a clear
  always @(posedge clk) begin
    if (!mm_reset_n) mcnt <= 0;
    else if (mm_enable) mcnt <= mcnt + 1;
  end
  assign mdl_valid = mm_enable && (mcnt == 2);
  assign mm_valid  = (use_model && mdl_valid) || man_valid;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [71:0] obs,
                     input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // start in cycle 0, 18 bytes in cycles 1..18, returns in cycle 19
  task automatic load_job();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 18; k++) begin
      in_valid = 1'b1;
      in_data  = vec[k];
      step();
    end
    in_valid = 1'b0;
  endtask

  int  acc;
  int  idx;
  int  en_cnt;
  logic got;

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1; start = 1'b0; in_data = '0; in_valid = 1'b0;
    use_model = 1'b0; man_valid = 1'b0;
    step(); step();
    chk("rst_in_ready", 72'(in_ready), 72'd0);
    chk("rst_mm_reset_n", 72'(mm_reset_n), 72'd0);
    chk("rst_mm_enable", 72'(mm_enable), 72'd0);
    chk("rst_busy", 72'(busy), 72'd0);
    chk("rst_done", 72'(done), 72'd0);
    chk("rst_error", 72'(error), 72'd0);
    chk("rst_A", A_mat, 72'd0);
    chk("rst_B", B_mat, 72'd0);
    reset = 1'b0;
    step();
    chk("idle_mm_reset_n", 72'(mm_reset_n), 72'd1);

    // 1: reset mid-LOAD
    start = 1'b1; step(); start = 1'b0;
    chk("t1_in_ready", 72'(in_ready), 72'd1);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_data = 8'(8'h31 + k); step();
    end
    in_valid = 1'b0;
    chk("t1_A_part", A_mat, 72'h313233343500000000);
    reset = 1'b1; step();
    chk("t1_busy", 72'(busy), 72'd0);
    chk("t1_A_clr", A_mat, 72'd0);
    chk("t1_in_ready0", 72'(in_ready), 72'd0);
    chk("t1_mm_reset_n", 72'(mm_reset_n), 72'd0);
    reset = 1'b0; step();
    start = 1'b1; step(); start = 1'b0;
    in_valid = 1'b1; in_data = 8'hAB; step(); in_valid = 1'b0;
    chk("t1_A_first", A_mat, 72'hAB0000000000000000);
    reset = 1'b1; step(); reset = 1'b0; step();

    // 2: identity A, B = 1..9, multiplier model
    use_model = 1'b1;
    for (int k = 0; k < 9; k++) vec[k] = (k % 4 == 0) ? 8'd1 : 8'd0;
    for (int k = 0; k < 9; k++) vec[9+k] = 8'(k + 1);
    load_job();
    chk("t2_c19_in_ready", 72'(in_ready), 72'd0);
    chk("t2_c19_mm_reset_n", 72'(mm_reset_n), 72'd0);
    chk("t2_c19_mm_enable", 72'(mm_enable), 72'd0);
    chk("t2_c19_busy", 72'(busy), 72'd1);
    step();
    chk("t2_c20_mm_enable", 72'(mm_enable), 72'd1);
    chk("t2_c20_mm_reset_n", 72'(mm_reset_n), 72'd1);
    chk("t2_A", A_mat, 72'h010000000100000001);
    chk("t2_B", B_mat, 72'h010203040506070809);
    step(); step();
    chk("t2_c22_done", 72'(done), 72'd0);
    step();
    chk("t2_c23_done", 72'(done), 72'd1);
    chk("t2_c23_mm_enable", 72'(mm_enable), 72'd0);
    chk("t2_c23_busy", 72'(busy), 72'd1);
    step();
    chk("t2_c24_done", 72'(done), 72'd0);
    chk("t2_c24_busy", 72'(busy), 72'd0);

    // 3: in_valid every other cycle
    start = 1'b1; step(); start = 1'b0;
    acc = 0; idx = 0;
    for (int c = 0; c < 60 && acc < 18; c++) begin
      if (c % 2 == 0) begin
        in_valid = 1'b1; in_data = 8'(8'h10 + idx);
      end else begin
        in_valid = 1'b0; in_data = 8'hEE;
      end
      if (in_valid && in_ready) begin
        acc++; idx++;
      end
      step();
    end
    in_valid = 1'b0;
    chk("t3_accepts", 72'(acc), 72'd18);
    chk("t3_in_ready", 72'(in_ready), 72'd0);
    chk("t3_B_last", 72'(B_mat[64:71]), 72'h21);
    chk("t3_A", A_mat, 72'h101112131415161718);
    chk("t3_B", B_mat, 72'h191A1B1C1D1E1F2021);
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      step();
      if (done) got = 1'b1;
    end
    chk("t3_done_seen", 72'(got), 72'd1);
    step(); step();

    // 4: timeout with mm_valid tied low
    use_model = 1'b0;
    for (int k = 0; k < 18; k++) vec[k] = 8'(8'h40 + k);
    load_job();
    step();
    en_cnt = 0; got = 1'b0;
    for (int c = 0; c < 40 && mm_enable; c++) begin
      en_cnt++;
      if (done) got = 1'b1;
      step();
    end
    chk("t4_enable_cycles", 72'(en_cnt), 72'd16);
    chk("t4_mm_enable", 72'(mm_enable), 72'd0);
    chk("t4_error", 72'(error), 72'd1);
    chk("t4_busy", 72'(busy), 72'd0);
    chk("t4_no_done", 72'(got | done), 72'd0);
    step(); step(); step();
    chk("t4_error_sticky", 72'(error), 72'd1);
    start = 1'b1; step(); start = 1'b0;
    chk("t4_error_cleared", 72'(error), 72'd0);
    chk("t4_restart_busy", 72'(busy), 72'd1);
    reset = 1'b1; step(); reset = 1'b0; step();

    // 5: mm_valid on the timeout cycle
    for (int k = 0; k < 18; k++) vec[k] = 8'(8'h50 + k);
    load_job();
    step();
    repeat (15) step();
    chk("t5_c35_mm_enable", 72'(mm_enable), 72'd1);
    man_valid = 1'b1; step(); man_valid = 1'b0;
    chk("t5_done", 72'(done), 72'd1);
    chk("t5_error", 72'(error), 72'd0);
    step();
    chk("t5_idle_busy", 72'(busy), 72'd0);
    chk("t5_idle_error", 72'(error), 72'd0);

    // 6: ignored start/in_valid/mm_valid
    use_model = 1'b1;
    for (int k = 0; k < 18; k++) vec[k] = 8'(8'h60 + k);
    load_job();
    step(); step();
    start = 1'b1; step(); start = 1'b0;
    step();
    chk("t6_c23_done", 72'(done), 72'd1);
    start = 1'b1; step(); start = 1'b0;
    chk("t6_c24_busy", 72'(busy), 72'd0);
    step();
    chk("t6_c25_in_ready", 72'(in_ready), 72'd0);
    in_valid = 1'b1; in_data = 8'hFF; man_valid = 1'b1;
    repeat (3) step();
    chk("t6_idle_busy", 72'(busy), 72'd0);
    chk("t6_idle_done", 72'(done), 72'd0);
    chk("t6_idle_mm_enable", 72'(mm_enable), 72'd0);
    chk("t6_A_held", A_mat, 72'h606162636465666768);
    chk("t6_B_held", B_mat, 72'h696A6B6C6D6E6F7071);
    in_valid = 1'b0; man_valid = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
